// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared types and constants for the multicycle MIPS controller
//   state_t  - FSM state encoding
//   OP_*     - supported opcodes (instruction[31:26])
//   FN_*     - supported R-type funct codes (instruction[5:0])
//   ALUC_*   - alucontrol encodings
//   aluop_t  - ALU operation class handed from the FSM to the ALU decoder
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
      S_ALUWB, S_BEQ, S_BNE, S_ADDIEX, S_ORIEX, S_IMMWB, S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OR} aluop_t;

   function automatic state_t decode_next(input logic [5:0] op);
      return (op == OP_LW || op == OP_SW) ? S_MEMADR :
             (op == OP_RTYPE)             ? S_EXECUTE :
             (op == OP_BEQ)               ? S_BEQ :
             (op == OP_BNE)               ? S_BNE :
             (op == OP_ADDI)              ? S_ADDIEX :
             (op == OP_ORI)               ? S_ORIEX :
             (op == OP_J)                 ? S_JUMP : S_FETCH;
   endfunction

   function automatic logic op_legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
   endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps aluop class plus funct to alucontrol
//   funct         in   R-type function field
//   aluop         in   operation class from the FSM
//   alucontrol    out  ALU operation select
//   funct_illegal out  funct is not decodable while aluop selects funct
module mc_aludec
   import mips_mc_pkg::*;
#(
   parameter int OP_W      = 6,
   parameter int ALUCTRL_W = 3
) (
   input  logic [OP_W-1:0]      funct,
   input  aluop_t               aluop,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 funct_illegal
);

   logic [5:0] f;
   logic [2:0] fc;
   logic       fok;

   assign f = 6'(funct);

   always_comb begin
      fok = 1'b1;
      fc  = ALUC_ADD;
      case (f)
         FN_ADD:  fc = ALUC_ADD;
         FN_SUB:  fc = ALUC_SUB;
         FN_AND:  fc = ALUC_AND;
         FN_OR:   fc = ALUC_OR;
         FN_SLT:  fc = ALUC_SLT;
         default: fok = 1'b0;
      endcase
      alucontrol    = ALUCTRL_W'(aluop == ALUOP_SUB   ? ALUC_SUB :
                                 aluop == ALUOP_OR    ? ALUC_OR  :
                                 aluop == ALUOP_FUNCT ? fc       : ALUC_ADD);
      funct_illegal = (aluop == ALUOP_FUNCT) && !fok;
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multicycle MIPS datapath
//   clk, reset            clock and asynchronous active-high reset
//   op, funct             instruction fields from the instruction register
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completed the current access this cycle
//   pcen .. alucontrol    datapath enables and mux selects
//   illegal_op            sticky flag for an undecodable op or funct
module multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int OP_W        = 6,
   parameter int ALUCTRL_W   = 3,
   parameter bit HAS_MEMWAIT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_W-1:0]      op,
   input  logic [OP_W-1:0]      funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pcen,
   output logic                 iord,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic                 immzext,
   output logic [1:0]           pcsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 illegal_op
);

   state_t     state, nxt;
   aluop_t     aluop;
   logic [5:0] o;
   logic       mr, pcwrite, branch, bne_br, irw, mw, rw, funct_illegal;

   assign o  = 6'(op);
   assign mr = HAS_MEMWAIT ? mem_ready : 1'b1;

   mc_aludec #(.OP_W(OP_W), .ALUCTRL_W(ALUCTRL_W)) u_aludec (
      .funct        (funct),
      .aluop        (aluop),
      .alucontrol   (alucontrol),
      .funct_illegal(funct_illegal)
   );

   always_comb begin
      nxt = S_FETCH;
      case (state)
         S_FETCH:   nxt = mr ? S_DECODE : S_FETCH;
         S_DECODE:  nxt = decode_next(o);
         S_MEMADR:  nxt = (o == OP_LW) ? S_MEMRD : (o == OP_SW) ? S_MEMWR : S_FETCH;
         S_MEMRD:   nxt = mr ? S_MEMWB : S_MEMRD;
         S_MEMWR:   nxt = mr ? S_FETCH : S_MEMWR;
         S_EXECUTE: nxt = funct_illegal ? S_FETCH : S_ALUWB;
         S_ADDIEX:  nxt = S_IMMWB;
         S_ORIEX:   nxt = S_IMMWB;
         default:   nxt = S_FETCH;
      endcase
   end

   always_comb begin
      iord     = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      immzext  = 1'b0;
      pcsrc    = 2'b00;
      aluop    = ALUOP_ADD;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne_br   = 1'b0;
      irw      = 1'b0;
      mw       = 1'b0;
      rw       = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb = 2'b01;
            irw     = mr;
            pcwrite = mr;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            rw       = 1'b1;
         end
         S_MEMWR: begin
            iord = 1'b1;
            mw   = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst = 1'b1;
            rw     = 1'b1;
         end
         S_BEQ: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_BNE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            bne_br  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ORIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = ALUOP_OR;
            immzext = 1'b1;
         end
         S_IMMWB:   rw = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write strobes are gated by reset so a mid-instruction reset kills them at once
   assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne_br & ~zero));
   assign memwrite = ~reset & mw;
   assign irwrite  = ~reset & irw;
   assign regwrite = ~reset & rw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         illegal_op <= 1'b0;
      end else begin
         state <= nxt;
         if ((state == S_DECODE && !op_legal(o)) || (state == S_EXECUTE && funct_illegal))
            illegal_op <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench driving directed instruction sequences
module tb_multicycle_controller;
   import mips_mc_pkg::*;

   logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
   logic [5:0] op = 6'd0, funct = 6'd0;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, immzext, illegal_op;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   typedef struct packed {logic [16:0] v; logic [16:0] m;} exp_t;
   typedef struct {exp_t e; string nm;} item_t;

   item_t q[$];
   int    nchk = 0, nerr = 0;
   bit    ill = 1'b0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .immzext(immzext), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // field order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb immzext pcsrc alucontrol illegal_op
   function automatic exp_t ev(string s, bit mr = 1, bit z = 0, logic [2:0] acx = 3'b010);
      logic pc = 0, io = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, asa = 0, imz = 0;
      logic [1:0] asb = 0, ps = 0;
      logic [2:0] ac = 0;
      logic [16:0] m = '0;
      case (s)
         "FETCH":    begin irw = mr; pc = mr; asb = 2'b01; ac = 3'b010; m = 17'b0_1_0_0_0_0_0_1_11_0_11_111_0; end
         "DECODE":   begin asb = 2'b11; ac = 3'b010; m = 17'b0_0_0_0_0_0_0_1_11_0_00_111_0; end
         "MEMADR":   begin asa = 1; asb = 2'b10; ac = 3'b010; m = 17'b0_0_0_0_0_0_0_1_11_0_00_111_0; end
         "MEMRD":    begin io = 1; m = 17'b0_1_0_0_0_0_0_0_00_0_00_000_0; end
         "MEMWB":    begin mtr = 1; rw = 1; m = 17'b0_0_0_0_1_1_0_0_00_0_00_000_0; end
         "MEMWR":    begin io = 1; mw = 1; m = 17'b0_1_0_0_0_0_0_0_00_0_00_000_0; end
         "EXECUTE":  begin asa = 1; ac = acx; m = 17'b0_0_0_0_0_0_0_1_11_0_00_111_0; end
         "EXECUTEX": begin asa = 1; m = 17'b0_0_0_0_0_0_0_1_11_0_00_000_0; end
         "ALUWB":    begin rd = 1; rw = 1; m = 17'b0_0_0_0_1_1_0_0_00_0_00_000_0; end
         "BEQ":      begin asa = 1; ac = 3'b110; ps = 2'b01; pc = z; m = 17'b0_0_0_0_0_0_0_1_11_0_11_111_0; end
         "BNE":      begin asa = 1; ac = 3'b110; ps = 2'b01; pc = !z; m = 17'b0_0_0_0_0_0_0_1_11_0_11_111_0; end
         "ADDIEX":   begin asa = 1; asb = 2'b10; ac = 3'b010; m = 17'b0_0_0_0_0_0_0_1_11_1_00_111_0; end
         "ORIEX":    begin asa = 1; asb = 2'b10; imz = 1; ac = 3'b001; m = 17'b0_0_0_0_0_0_0_1_11_1_00_111_0; end
         "IMMWB":    begin rw = 1; m = 17'b0_0_0_0_1_1_0_0_00_0_00_000_0; end
         "JUMP":     begin ps = 2'b10; pc = 1; m = 17'b0_0_0_0_0_0_0_0_00_0_11_000_0; end
         default: ;
      endcase
      ev.v = {pc, io, mw, irw, rd, mtr, rw, asa, asb, imz, ps, ac, ill};
      ev.m = m | 17'b1_0_1_1_0_0_1_0_00_0_00_000_1;
   endfunction

   task automatic push(string nm, exp_t e);
      item_t it;
      it.e  = e;
      it.nm = nm;
      q.push_back(it);
   endtask

   task automatic step(string nm, string s, bit mr = 1, bit z = 0, logic [2:0] acx = 3'b010);
      mem_ready = mr;
      zero      = z;
      push(nm, ev(s, mr, z, acx));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         logic [16:0] act;
         it  = q.pop_front();
         act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                immzext, pcsrc, alucontrol, illegal_op};
         nchk++;
         if ((act & it.e.m) !== (it.e.v & it.e.m)) begin
            nerr++;
            $display("FAIL %s actual=%b required=%b care=%b", it.nm, act, it.e.v, it.e.m);
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      push("reset", ev("FETCH", 0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      op = OP_LW;
      step("lw_fetch", "FETCH"); step("lw_dec", "DECODE"); step("lw_adr", "MEMADR");
      step("lw_rd", "MEMRD"); step("lw_wb", "MEMWB");
      op = OP_BEQ;
      step("beq1_f", "FETCH"); step("beq1_d", "DECODE"); step("beq1_taken", "BEQ", 1, 1);
      step("beq0_f", "FETCH"); step("beq0_d", "DECODE"); step("beq0_not", "BEQ", 1, 0);
      op = OP_BNE;
      step("bne1_f", "FETCH"); step("bne1_d", "DECODE"); step("bne1_not", "BNE", 1, 1);
      step("bne0_f", "FETCH"); step("bne0_d", "DECODE"); step("bne0_taken", "BNE", 1, 0);
      op = OP_J;
      step("j_f", "FETCH"); step("j_d", "DECODE"); step("j_jump", "JUMP");
      op = OP_SW;
      step("sw_f", "FETCH"); step("sw_d", "DECODE"); step("sw_adr", "MEMADR");
      for (int i = 0; i < 3; i++) step("sw_wait", "MEMWR", 0);
      step("sw_done", "MEMWR", 1);
      op = OP_ADDI;
      step("addi_fwait", "FETCH", 0); step("addi_fwait", "FETCH", 0); step("addi_f", "FETCH");
      step("addi_d", "DECODE"); step("addi_ex", "ADDIEX"); step("addi_wb", "IMMWB");
      op = OP_ORI;
      step("ori_f", "FETCH"); step("ori_d", "DECODE"); step("ori_ex", "ORIEX"); step("ori_wb", "IMMWB");
      op = OP_LW;
      step("lw2_f", "FETCH"); step("lw2_d", "DECODE"); step("lw2_adr", "MEMADR");
      step("lw2_rdwait", "MEMRD", 0); step("lw2_rd", "MEMRD", 1); step("lw2_wb", "MEMWB");
      op = OP_RTYPE;
      funct = FN_SLT;
      step("slt_f", "FETCH"); step("slt_d", "DECODE"); step("slt_ex", "EXECUTE", 1, 0, 3'b111); step("slt_wb", "ALUWB");
      funct = FN_SUB;
      step("sub_f", "FETCH"); step("sub_d", "DECODE"); step("sub_ex", "EXECUTE", 1, 0, 3'b110); step("sub_wb", "ALUWB");
      funct = FN_AND;
      step("and_f", "FETCH"); step("and_d", "DECODE"); step("and_ex", "EXECUTE", 1, 0, 3'b000); step("and_wb", "ALUWB");
      funct = FN_OR;
      step("or_f", "FETCH"); step("or_d", "DECODE"); step("or_ex", "EXECUTE", 1, 0, 3'b001); step("or_wb", "ALUWB");
      funct = 6'b111111;
      step("badfn_f", "FETCH"); step("badfn_d", "DECODE"); step("badfn_ex", "EXECUTEX");
      ill = 1'b1;
      op = OP_LW;
      step("lw3_f", "FETCH"); step("lw3_d", "DECODE"); step("lw3_adr", "MEMADR"); step("lw3_rd", "MEMRD");
      push("lw3_wb", ev("MEMWB"));
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      nchk++;
      if ({regwrite, irwrite, pcen, memwrite, iord, illegal_op} !== 6'b0) begin
         nerr++;
         $display("FAIL async_reset actual=%b required=000000", {regwrite, irwrite, pcen, memwrite, iord, illegal_op});
      end
      ill = 1'b0;
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      push("rst_hold", ev("FETCH", 0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      op = 6'b111111;
      step("badop_f", "FETCH"); step("badop_d", "DECODE");
      ill = 1'b1;
      op = OP_ADDI;
      step("addi2_f", "FETCH"); step("addi2_d", "DECODE"); step("addi2_ex", "ADDIEX"); step("addi2_wb", "IMMWB");
      op = OP_J;
      step("end_f", "FETCH");
      @(negedge clk);
      #1;
      nchk++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
